regfile_scoreboard: RTL and testbench

- Architectural register file of the five-stage MIPS pipeline, with a per-register pending-write scoreboard.
- Position in the pipeline:
  - Decode reads its two source operands and issues destination reservations here.
  - The write-back stage delivers final writes here.
- The block raises a hazard stall when decode needs a register that still has an outstanding write.
- Same-cycle write-back data is bypassed to the read ports.

---
 rtl/mips_pkg.sv | 15 +
 rtl/sb_counter.sv | 50 +++++
 rtl/regfile_scoreboard.sv | 114 +++++++++++
 tb/tb_regfile_scoreboard.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS register file and its scoreboard.
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int CNT_W    = 2;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

  // Hard-wired zero register.
  localparam reg_addr_t R0 = '0;

endpackage

// File: rtl/sb_counter.sv
// Pending-write counter for one architectural register. Counts up on an
// accepted issue and down on write-back and cancel. It flags underflow when
// the decrements exceed what is outstanding, and clamps at zero in that case.
module sb_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec_a,
  input  logic         dec_b,
  output logic [W-1:0] count,
  output logic         busy,
  output logic         full,
  output logic         underflow
);

  logic [W-1:0] count_reg;
  logic [W+1:0] after_dec;
  logic [W+1:0] total;

  // Two guard bits hold the range -2 .. 2^W. The top bit is the sign.
  always_comb begin
    after_dec = {2'b00, count_reg}
              - {{(W+1){1'b0}}, dec_a}
              - {{(W+1){1'b0}}, dec_b};
    total     = after_dec + {{(W+1){1'b0}}, inc};
    underflow = total[W+1];
    busy      = !after_dec[W+1] && (after_dec != '0);
    full      = &count_reg;
  end

  // The count register clamps at zero on underflow and at the maximum on
  // overflow. Overflow cannot happen here because the caller gates inc
  // with full.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (underflow) begin
      count_reg <= '0;
    end else if (total[W]) begin
      count_reg <= '1;
    end else begin
      count_reg <= total[W-1:0];
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/regfile_scoreboard.sv
// Architectural register file with a per-register pending-write scoreboard.
// It provides combinational reads with same-cycle write-back bypass, and
// raises a hazard stall when decode needs an operand that is still pending.
module regfile_scoreboard
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int CNT_W  = mips_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              rs_used,
  input  logic              rt_used,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              issue_valid,
  input  logic              issue_wr,
  input  logic [ADDR_W-1:0] issue_dst,
  input  logic              cancel_valid,
  input  logic [ADDR_W-1:0] cancel_dst,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              hazard_stall,
  output logic              sb_err
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(R0);

  logic [DATA_W-1:0] regs [NREG];
  logic [CNT_W-1:0]  cnt  [NREG];
  logic [NREG-1:0]   busy_vec;
  logic [NREG-1:0]   full_vec;
  logic [NREG-1:0]   uflow_vec;
  logic              issue_acc;
  logic              sb_err_reg;

  // r0 never holds a reservation.
  assign cnt[0]       = '0;
  assign busy_vec[0]  = 1'b0;
  assign full_vec[0]  = 1'b0;
  assign uflow_vec[0] = 1'b0;

  // An issue counts only when decode is not frozen and no hazard is holding it.
  assign issue_acc = issue_valid & issue_wr & ~stall & ~hazard_stall
                   & (issue_dst != ZERO_ADDR);

  // One scoreboard counter per real register, r1..r(NREG-1).
  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_cnt
      logic issue_hit;
      logic wb_hit;
      logic cancel_hit;
      assign issue_hit  = issue_acc    & (issue_dst  == ADDR_W'(gi));
      assign wb_hit     = wb_en        & (wb_addr    == ADDR_W'(gi));
      assign cancel_hit = cancel_valid & (cancel_dst == ADDR_W'(gi));

      sb_counter #(.W(CNT_W)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .inc       (issue_hit),
        .dec_a     (wb_hit),
        .dec_b     (cancel_hit),
        .count     (cnt[gi]),
        .busy      (busy_vec[gi]),
        .full      (full_vec[gi]),
        .underflow (uflow_vec[gi])
      );
    end
  endgenerate

  // Hazard check uses busy after same-cycle completions, plus counter saturation.
  always_comb begin
    hazard_stall = issue_valid & ((rs_used  & busy_vec[rs_addr])
                               |  (rt_used  & busy_vec[rt_addr])
                               |  (issue_wr & full_vec[issue_dst]));
  end

  // Read ports: r0 is zero, then the write-back bypass, then the array.
  always_comb begin
    rs_data = regs[rs_addr];
    rt_data = regs[rt_addr];
    if (wb_en && wb_addr == rs_addr) rs_data = wb_data;
    if (wb_en && wb_addr == rt_addr) rt_data = wb_data;
    if (rs_addr == ZERO_ADDR) rs_data = '0;
    if (rt_addr == ZERO_ADDR) rt_data = '0;
  end

  // Register array write. The counter value does not gate the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en && wb_addr != ZERO_ADDR) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Sticky error: some counter saw more completions than it had reservations.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_err_reg <= 1'b0;
    end else if (|uflow_vec) begin
      sb_err_reg <= 1'b1;
    end
  end

  assign sb_err = sb_err_reg;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios followed by
// random traffic. Every cycle is compared against a behavioural model.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [4:0]  rs_addr, rt_addr;
  logic        rs_used, rt_used;
  logic [31:0] rs_data, rt_data;
  logic        issue_valid, issue_wr;
  logic [4:0]  issue_dst;
  logic        cancel_valid;
  logic [4:0]  cancel_dst;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        hazard_stall;
  logic        sb_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state.
  int          m_cnt  [32];
  logic [31:0] m_regs [32];
  logic        m_err;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_used      (rs_used),
    .rt_used      (rt_used),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .issue_valid  (issue_valid),
    .issue_wr     (issue_wr),
    .issue_dst    (issue_dst),
    .cancel_valid (cancel_valid),
    .cancel_dst   (cancel_dst),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .hazard_stall (hazard_stall),
    .sb_err       (sb_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic bit m_busy(input logic [4:0] a);
    int d;
    if (a == 0) return 1'b0;
    d = m_cnt[a] - int'(wb_en && wb_addr == a) - int'(cancel_valid && cancel_dst == a);
    return d > 0;
  endfunction

  function automatic logic m_hazard();
    return issue_valid && ((rs_used && m_busy(rs_addr)) ||
                           (rt_used && m_busy(rt_addr)) ||
                           (issue_wr && m_cnt[issue_dst] == 3));
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wb_en && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  // The single per-cycle compare of every DUT output against the model.
  task automatic check_outputs();
    chk("rs_data", rs_data, m_read(rs_addr));
    chk("rt_data", rt_data, m_read(rt_addr));
    chk("hazard_stall", {31'b0, hazard_stall}, {31'b0, m_hazard()});
    chk("sb_err", {31'b0, sb_err}, {31'b0, m_err});
  endtask

  // Advances the model by one clock edge, using the inputs held across the edge.
  task automatic model_update();
    bit acc;
    int n;
    if (rst) begin
      for (int r = 0; r < 32; r++) begin m_cnt[r] = 0; m_regs[r] = 32'h0; end
      m_err = 1'b0;
      return;
    end
    acc = issue_valid && issue_wr && !stall && !m_hazard() && issue_dst != 0;
    for (int r = 1; r < 32; r++) begin
      n = m_cnt[r] + int'(acc && issue_dst == r) - int'(wb_en && wb_addr == r)
        - int'(cancel_valid && cancel_dst == r);
      if (n < 0) begin n = 0; m_err = 1'b1; end
      m_cnt[r] = n;
    end
    if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
  endtask

  task automatic eval();
    #1;
    check_outputs();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; rs_addr = 0; rt_addr = 0; rs_used = 0; rt_used = 0;
    issue_valid = 0; issue_wr = 0; issue_dst = 0;
    cancel_valid = 0; cancel_dst = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
  endtask

  task automatic issue_to(input logic [4:0] d);
    issue_valid = 1; issue_wr = 1; issue_dst = d;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin m_cnt[r] = 0; m_regs[r] = 32'h0; end
    m_err = 1'b0;
    clear_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;

    // Reset state.
    clear_inputs(); rs_addr = 5; rt_addr = 0; eval();
    chk("rst_rs_data", rs_data, 32'h0);
    chk("rst_rt_data", rt_data, 32'h0);
    chk("rst_hazard", {31'b0, hazard_stall}, 32'h0);
    chk("rst_sb_err", {31'b0, sb_err}, 32'h0);
    tick();

    // A RAW hazard on r8 is released by the same-cycle write-back.
    clear_inputs(); issue_to(8); eval(); tick();
    clear_inputs(); issue_valid = 1; rs_used = 1; rs_addr = 8; eval();
    chk("raw_hazard_r8", {31'b0, hazard_stall}, 32'h1);
    tick();
    wb_en = 1; wb_addr = 8; wb_data = 32'hDEADBEEF; eval();
    chk("wb_release_r8", {31'b0, hazard_stall}, 32'h0);
    chk("bypass_r8", rs_data, 32'hDEADBEEF);
    tick();
    clear_inputs(); rs_addr = 8; eval();
    chk("stored_r8", rs_data, 32'hDEADBEEF);
    tick();

    // Saturate r3, then drain it.
    for (int i = 0; i < 3; i++) begin clear_inputs(); issue_to(3); eval(); tick(); end
    clear_inputs(); issue_to(3); eval();
    chk("sat_hazard_r3", {31'b0, hazard_stall}, 32'h1);
    tick();
    chk("model_cnt3_sat", m_cnt[3], 32'd3);
    for (int i = 0; i < 3; i++) begin
      clear_inputs(); wb_en = 1; wb_addr = 3; wb_data = $urandom; eval(); tick();
    end
    clear_inputs(); issue_valid = 1; rs_used = 1; rs_addr = 3; eval();
    chk("drained_r3", {31'b0, hazard_stall}, 32'h0);
    chk("model_cnt3_zero", m_cnt[3], 32'd0);
    tick();

    // Combine issue, write-back and cancel on r4 in the same cycle.
    clear_inputs(); issue_to(4); eval(); tick();
    clear_inputs(); issue_to(4); wb_en = 1; wb_addr = 4; wb_data = 32'h44; eval(); tick();
    chk("model_cnt4_same", m_cnt[4], 32'd1);
    clear_inputs(); issue_to(4); wb_en = 1; wb_addr = 4; wb_data = 32'h45;
    cancel_valid = 1; cancel_dst = 4; eval(); tick();
    chk("model_cnt4_zero", m_cnt[4], 32'd0);
    clear_inputs(); issue_valid = 1; rt_used = 1; rt_addr = 4; eval();
    chk("r4_not_busy", {31'b0, hazard_stall}, 32'h0);
    chk("r4_value", rt_data, 32'h45);
    tick();

    // Writes to r0 are ignored. A write-back to r9 with no reservation sets the error.
    clear_inputs(); wb_en = 1; wb_addr = 0; wb_data = 32'h1234; rs_addr = 0; eval();
    chk("r0_bypass", rs_data, 32'h0);
    tick();
    clear_inputs(); eval();
    chk("r0_no_err", {31'b0, sb_err}, 32'h0);
    tick();
    clear_inputs(); wb_en = 1; wb_addr = 9; wb_data = 32'hCAFE0009; eval(); tick();
    clear_inputs(); rs_addr = 9; eval();
    chk("r9_written", rs_data, 32'hCAFE0009);
    chk("r9_sb_err", {31'b0, sb_err}, 32'h1);
    tick(); tick();
    clear_inputs(); eval();
    chk("sb_err_sticky", {31'b0, sb_err}, 32'h1);
    tick();

    // An issue while decode is frozen must not reserve r7.
    clear_inputs(); stall = 1; issue_to(7); eval(); tick();
    chk("model_cnt7_stall", m_cnt[7], 32'd0);
    clear_inputs(); issue_valid = 1; rs_used = 1; rs_addr = 7; eval();
    chk("r7_not_busy", {31'b0, hazard_stall}, 32'h0);
    tick();

    // Reset clears the sticky error.
    clear_inputs(); rst = 1; eval(); tick();
    rst = 0; eval();
    chk("rst_clears_err", {31'b0, sb_err}, 32'h0);
    tick();

    // Random traffic on a small register window so events collide often.
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 399) == 0);
      stall        = ($urandom_range(0, 7) == 0);
      rs_addr      = 5'($urandom_range(0, 7));
      rt_addr      = 5'($urandom_range(0, 7));
      rs_used      = $urandom_range(0, 1) == 1;
      rt_used      = $urandom_range(0, 1) == 1;
      issue_valid  = $urandom_range(0, 9) < 7;
      issue_wr     = $urandom_range(0, 9) < 8;
      issue_dst    = 5'($urandom_range(0, 7));
      cancel_valid = $urandom_range(0, 9) == 0;
      cancel_dst   = 5'($urandom_range(0, 7));
      wb_en        = $urandom_range(0, 9) < 4;
      wb_addr      = 5'($urandom_range(0, 7));
      wb_data      = $urandom;
      eval();
      tick();
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
